// File: rtl/flash_port_arbiter_pkg.sv
// Shared definitions for the flash port arbiter slice.
// Contents: default byte-address width, word width, the arbiter FSM
// state encoding and a helper that derives the line-buffer tag width
// from an address width (tag = byte address without the 2 offset bits).
package flash_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 24;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned TAG_W_DEF  = ADDR_W_DEF - 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } arb_state_t;

  function automatic int unsigned tag_width(input int unsigned addr_w);
    return addr_w - 2;
  endfunction

endpackage

// File: rtl/flash_port_arbiter_if.sv
// Bus bundle between the requesters / flash word reader and the arbiter.
// Requester side: req_valid, req_addr (port p at [p*ADDR_W +: ADDR_W]),
//   req_ready (one-cycle completion pulse), req_rdata (port p at
//   [p*32 +: 32]), inval (clear all line buffers).
// Flash side: mem_valid, mem_addr (word aligned), mem_ready (one-cycle
//   done pulse), mem_rdata.
// slave  : the arbiter's view.
// master : the surrounding system's view (requesters plus flash reader).
interface flash_port_arbiter_if
  import flash_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned ADDR_W    = ADDR_W_DEF
);

  logic [NUM_PORTS-1:0]        req_valid;
  logic [NUM_PORTS*ADDR_W-1:0] req_addr;
  logic [NUM_PORTS-1:0]        req_ready;
  logic [NUM_PORTS*WORD_W-1:0] req_rdata;
  logic                        inval;
  logic                        mem_valid;
  logic [ADDR_W-1:0]           mem_addr;
  logic                        mem_ready;
  logic [WORD_W-1:0]           mem_rdata;

  modport slave (
    input  req_valid, req_addr, inval, mem_ready, mem_rdata,
    output req_ready, req_rdata, mem_valid, mem_addr
  );

  modport master (
    output req_valid, req_addr, inval, mem_ready, mem_rdata,
    input  req_ready, req_rdata, mem_valid, mem_addr
  );

endinterface

// File: rtl/flash_line_buf.sv
// One-word line buffer for a single requester port.
// Ports: clk, resetn (sync, active-low); lookup_tag / hit: combinational
// tag compare against the stored word; data: stored word; fill, fill_tag,
// fill_data: write a new word and mark it valid; clear: drop the valid bit.
// A clear coinciding with a fill still writes tag and data (the arbiter
// returns the fill word from here) but leaves the entry invalid.
module flash_line_buf
  import flash_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [tag_width(ADDR_W)-1:0]  lookup_tag,
  output logic                          hit,
  output logic [WORD_W-1:0]             data,
  input  logic                          fill,
  input  logic [tag_width(ADDR_W)-1:0]  fill_tag,
  input  logic [WORD_W-1:0]             fill_data,
  input  logic                          clear
);

  localparam int unsigned TAG_W = tag_width(ADDR_W);

  logic [TAG_W-1:0]  tag_q;
  logic [WORD_W-1:0] data_q;
  logic              valid_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      tag_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      if (fill) begin
        tag_q  <= fill_tag;
        data_q <= fill_data;
      end
      if (clear) begin
        valid_q <= 1'b0;
      end else if (fill) begin
        valid_q <= 1'b1;
      end
    end
  end

  assign hit  = valid_q && (tag_q == lookup_tag);
  assign data = data_q;

endmodule

// File: rtl/flash_port_arbiter.sv
// Shares one SPI flash word reader between NUM_PORTS requesters.
// Ports: clk, resetn (sync, active-low), bus (flash_port_arbiter_if.slave,
// carrying the per-port request/response signals, inval and the flash
// reader handshake).
// Each port owns a one-word line buffer; hits answer one cycle later on
// all ports in parallel. Misses are granted round-robin and issued to the
// flash one at a time (IDLE -> ISSUE -> DONE), with mem_valid dropped for
// at least one cycle between transactions.
module flash_port_arbiter
  import flash_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned ADDR_W    = ADDR_W_DEF
) (
  input logic                  clk,
  input logic                  resetn,
  flash_port_arbiter_if.slave  bus
);

  localparam int unsigned PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  arb_state_t        state, state_n;
  logic [PW-1:0]     grant, grant_n;
  logic [PW-1:0]     rr, rr_n;
  logic [PW-1:0]     pick;
  logic              found;
  logic              mem_valid_q, mem_valid_n;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_n;

  logic [NUM_PORTS-1:0] ready_q, ready_n;
  logic [NUM_PORTS-1:0] buf_hit, hit, miss, fill, done_resp;
  logic [WORD_W-1:0]    rdata_q  [NUM_PORTS];
  logic [WORD_W-1:0]    rdata_n  [NUM_PORTS];
  logic [WORD_W-1:0]    buf_data [NUM_PORTS];
  logic [ADDR_W-1:0]    addr_a   [NUM_PORTS];

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign addr_a[p] = bus.req_addr[p*ADDR_W +: ADDR_W];

    flash_line_buf #(.ADDR_W(ADDR_W)) u_buf (
      .clk        (clk),
      .resetn     (resetn),
      .lookup_tag (addr_a[p][ADDR_W-1:2]),
      .hit        (buf_hit[p]),
      .data       (buf_data[p]),
      .fill       (fill[p]),
      .fill_tag   (mem_addr_q[ADDR_W-1:2]),
      .fill_data  (bus.mem_rdata),
      .clear      (bus.inval)
    );

    // A port already pulsing ready this cycle is neither a hit nor a miss:
    // its requester is about to drop valid.
    assign hit[p]  = bus.req_valid[p] & buf_hit[p] & ~ready_q[p];
    assign miss[p] = bus.req_valid[p] & ~hit[p] & ~ready_q[p];

    assign fill[p]      = (state == ST_ISSUE) && bus.mem_ready && (grant == PW'(p));
    assign done_resp[p] = (state == ST_DONE) && bus.req_valid[p] && (grant == PW'(p));

    // Both response paths read the buffer: a fill always writes the data,
    // even when a coincident inval keeps the entry invalid.
    assign ready_n[p] = hit[p] | done_resp[p];
    assign rdata_n[p] = ready_n[p] ? buf_data[p] : rdata_q[p];

    assign bus.req_rdata[p*WORD_W +: WORD_W] = rdata_q[p];
  end

  // Round-robin pick: first miss at or after rr, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = rr;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      int unsigned   cand_w;
      logic [PW-1:0] cand;
      cand_w = 32'(rr) + i;
      if (cand_w >= NUM_PORTS) cand_w = cand_w - NUM_PORTS;
      cand = PW'(cand_w);
      if (!found && miss[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_n     = state;
    grant_n     = grant;
    rr_n        = rr;
    mem_valid_n = mem_valid_q;
    mem_addr_n  = mem_addr_q;
    case (state)
      ST_IDLE: begin
        if (found) begin
          grant_n     = pick;
          mem_addr_n  = addr_a[pick] & ~ADDR_W'(3);
          mem_valid_n = 1'b1;
          state_n     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (bus.mem_ready) begin
          mem_valid_n = 1'b0;
          state_n     = ST_DONE;
        end
      end
      ST_DONE: begin
        rr_n    = (grant == PW'(NUM_PORTS - 1)) ? '0 : grant + PW'(1);
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      grant       <= '0;
      rr          <= '0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      ready_q     <= '0;
      rdata_q     <= '{default: '0};
    end else begin
      state       <= state_n;
      grant       <= grant_n;
      rr          <= rr_n;
      mem_valid_q <= mem_valid_n;
      mem_addr_q  <= mem_addr_n;
      ready_q     <= ready_n;
      rdata_q     <= rdata_n;
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_addr  = mem_addr_q;

endmodule

// File: tb/tb_flash_port_arbiter.sv
// Directed self-checking bench for flash_port_arbiter (2 ports, 24-bit
// addresses) with a fixed-latency flash reader model that aborts when
// mem_valid drops.
module tb_flash_port_arbiter;

  localparam int NP     = 2;
  localparam int AW     = 24;
  localparam int FL_LAT = 4;
  // valid at negedge N0 -> grant P1 -> mem_ready after P(1+FL_LAT) ->
  // fill -> DONE -> req_ready seen at negedge N(FL_LAT+3)
  localparam int MISS_LAT = FL_LAT + 3;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  flash_port_arbiter_if #(.NUM_PORTS(NP), .ADDR_W(AW)) bus ();

  flash_port_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int   checks    = 0;
  int   errors    = 0;
  int   cyc       = 0;
  int   txn       = 0;
  int   mr_cyc    = 0;
  int   gap_err   = 0;
  int   mv_cycles = 0;
  int   fl_cnt    = 0;
  logic fl_armed  = 1'b1;
  logic prev_rdy  = 1'b0;

  function automatic logic [31:0] mdl(input logic [23:0] a);
    logic [23:0] w;
    w = {a[23:2], 2'b00};
    if (w == 24'h100000) return 32'hDDCCBBAA;
    return 32'h1234_5678 ^ {w, 8'h00};
  endfunction

  // Flash reader model plus cycle/transaction bookkeeping.
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    prev_rdy <= bus.mem_ready;
    if (prev_rdy === 1'b1 && bus.mem_valid === 1'b1) gap_err <= gap_err + 1;
    if (bus.mem_valid === 1'b1) mv_cycles <= mv_cycles + 1;
    bus.mem_ready <= 1'b0;
    if (bus.mem_valid !== 1'b1) begin
      fl_cnt   <= 0;
      fl_armed <= 1'b1;
    end else if (fl_armed) begin
      if (fl_cnt == FL_LAT - 1) begin
        bus.mem_ready <= 1'b1;
        bus.mem_rdata <= mdl(bus.mem_addr);
        fl_armed      <= 1'b0;
        txn           <= txn + 1;
        mr_cyc        <= cyc + 1;
      end else begin
        fl_cnt <= fl_cnt + 1;
      end
    end
  end

  // A requester must hold req_addr while its request is pending.
  logic [NP-1:0] v_q = '0;
  logic [NP-1:0] r_q = '0;
  logic [AW-1:0] a_q [NP];
  always @(posedge clk) begin
    for (int p = 0; p < NP; p++) begin
      if (resetn === 1'b1 && v_q[p] && !r_q[p] && bus.req_valid[p] === 1'b1)
        assert (bus.req_addr[p*AW +: AW] == a_q[p])
          else $error("req_addr of port %0d changed while pending", p);
      v_q[p] <= bus.req_valid[p];
      r_q[p] <= bus.req_ready[p];
      a_q[p] <= bus.req_addr[p*AW +: AW];
    end
  end

  task automatic do_req(input int p, input logic [23:0] a, output logic [31:0] d,
                        output int lat, output int rc, output bit ok);
    d = '0; lat = 0; rc = 0; ok = 1'b0;
    @(negedge clk);
    bus.req_addr[p*AW +: AW] = a;
    bus.req_valid[p] = 1'b1;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      lat++;
      if (bus.req_ready[p] === 1'b1) begin
        d  = bus.req_rdata[p*32 +: 32];
        rc = cyc;
        ok = 1'b1;
      end
    end
    bus.req_valid[p] = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got %b exp 00", bus.req_ready); end
    checks++; if (bus.req_rdata !== 64'h0) begin errors++; $display("FAIL reset_req_rdata got %h exp 0", bus.req_rdata); end
    checks++; if (bus.mem_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_valid got %b exp 0", bus.mem_valid); end
    checks++; if (bus.mem_addr !== 24'h0) begin errors++; $display("FAIL reset_mem_addr got %h exp 0", bus.mem_addr); end
    resetn = 1'b1;
  endtask

  task automatic test_cold_miss;
    logic [31:0] d; int lat, rc, t0; bit ok;
    t0 = txn;
    do_req(0, 24'h100002, d, lat, rc, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL cold_done got %0b exp 1", ok); end
    checks++; if (d !== 32'hDDCCBBAA) begin errors++; $display("FAIL cold_data got %h exp DDCCBBAA", d); end
    checks++; if (bus.mem_addr !== 24'h100000) begin errors++; $display("FAIL cold_mem_addr got %h exp 100000", bus.mem_addr); end
    checks++; if (txn !== t0 + 1) begin errors++; $display("FAIL cold_txn got %0d exp %0d", txn, t0 + 1); end
    checks++; if (rc - mr_cyc !== 2) begin errors++; $display("FAIL cold_ready_after_mem_ready got %0d exp 2", rc - mr_cyc); end
    checks++; if (lat !== MISS_LAT) begin errors++; $display("FAIL cold_latency got %0d exp %0d", lat, MISS_LAT); end
  endtask

  task automatic test_hit;
    logic [31:0] d; int lat, rc, t0, mv0; bit ok;
    t0 = txn; mv0 = mv_cycles;
    do_req(0, 24'h100001, d, lat, rc, ok);
    checks++; if (lat !== 1 || ok !== 1'b1) begin errors++; $display("FAIL hit_latency got %0d ok %0b exp 1", lat, ok); end
    checks++; if (d !== 32'hDDCCBBAA) begin errors++; $display("FAIL hit_data got %h exp DDCCBBAA", d); end
    checks++; if (txn !== t0 || mv_cycles !== mv0) begin errors++; $display("FAIL hit_no_flash got txn %0d mv %0d exp txn %0d mv %0d", txn, mv_cycles, t0, mv0); end
  endtask

  task automatic test_contention;
    logic [31:0] d0, d1, d; int l0, l1, c0, c1, l, c, t0; bit k0, k1, k;
    @(negedge clk) resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    t0 = txn;
    fork
      do_req(0, 24'h000000, d0, l0, c0, k0);
      do_req(1, 24'h200000, d1, l1, c1, k1);
    join
    checks++; if (k0 !== 1'b1 || k1 !== 1'b1) begin errors++; $display("FAIL cont1_done got %0b%0b exp 11", k0, k1); end
    checks++; if ((c0 < c1) !== 1'b1) begin errors++; $display("FAIL cont1_order got p0@%0d p1@%0d exp p0 first", c0, c1); end
    checks++; if (d0 !== mdl(24'h000000) || d1 !== mdl(24'h200000)) begin errors++; $display("FAIL cont1_data got %h %h exp %h %h", d0, d1, mdl(24'h000000), mdl(24'h200000)); end
    checks++; if (txn !== t0 + 2) begin errors++; $display("FAIL cont1_txn got %0d exp %0d", txn, t0 + 2); end
    do_req(0, 24'h500000, d, l, c, k);
    fork
      do_req(0, 24'h300000, d0, l0, c0, k0);
      do_req(1, 24'h600000, d1, l1, c1, k1);
    join
    checks++; if ((c1 < c0) !== 1'b1 || k0 !== 1'b1 || k1 !== 1'b1) begin errors++; $display("FAIL cont2_order got p0@%0d p1@%0d exp p1 first", c0, c1); end
    checks++; if (d0 !== mdl(24'h300000) || d1 !== mdl(24'h600000)) begin errors++; $display("FAIL cont2_data got %h %h exp %h %h", d0, d1, mdl(24'h300000), mdl(24'h600000)); end
    checks++; if (gap_err !== 0) begin errors++; $display("FAIL mem_valid_gap got %0d exp 0", gap_err); end
  endtask

  task automatic test_parallel_hit;
    logic [31:0] d0, d1; int l0, l1, c0, c1; bit k0, k1;
    fork
      do_req(0, 24'h700000, d0, l0, c0, k0);
      begin
        repeat (2) @(negedge clk);
        checks++; if (bus.mem_valid !== 1'b1) begin errors++; $display("FAIL par_in_issue got %b exp 1", bus.mem_valid); end
        do_req(1, 24'h600000, d1, l1, c1, k1);
      end
    join
    checks++; if (l1 !== 1 || k1 !== 1'b1 || d1 !== mdl(24'h600000)) begin errors++; $display("FAIL par_hit got lat %0d data %h exp 1 %h", l1, d1, mdl(24'h600000)); end
    checks++; if (k0 !== 1'b1 || d0 !== mdl(24'h700000) || l0 !== MISS_LAT) begin errors++; $display("FAIL par_miss got lat %0d data %h exp %0d %h", l0, d0, MISS_LAT, mdl(24'h700000)); end
  endtask

  task automatic test_inval;
    logic [31:0] d; int l, c, t0; bit k, seen;
    do_req(0, 24'h100002, d, l, c, k);
    t0 = txn;
    do_req(0, 24'h100002, d, l, c, k);
    checks++; if (txn !== t0 || l !== 1) begin errors++; $display("FAIL inval_prehit got txn %0d lat %0d exp %0d 1", txn, l, t0); end
    @(negedge clk) bus.inval = 1'b1;
    @(negedge clk) bus.inval = 1'b0;
    do_req(0, 24'h100002, d, l, c, k);
    checks++; if (txn !== t0 + 1 || d !== 32'hDDCCBBAA) begin errors++; $display("FAIL inval_remiss got txn %0d data %h exp %0d DDCCBBAA", txn, d, t0 + 1); end
    seen = 1'b0;
    fork
      do_req(0, 24'h800000, d, l, c, k);
      for (int i = 0; i < 40 && !seen; i++) begin
        @(negedge clk);
        if (bus.mem_ready === 1'b1) begin
          bus.inval = 1'b1;
          seen = 1'b1;
          @(negedge clk) bus.inval = 1'b0;
        end
      end
    join
    checks++; if (seen !== 1'b1 || k !== 1'b1 || d !== mdl(24'h800000)) begin errors++; $display("FAIL inval_fill_data got seen %0b data %h exp 1 %h", seen, d, mdl(24'h800000)); end
    t0 = txn;
    do_req(0, 24'h800000, d, l, c, k);
    checks++; if (txn !== t0 + 1 || l !== MISS_LAT) begin errors++; $display("FAIL inval_fill_not_kept got txn %0d lat %0d exp %0d %0d", txn, l, t0 + 1, MISS_LAT); end
  endtask

  task automatic test_abort_reset;
    logic [31:0] d; int l, c, t0, rdy; bit k;
    do_req(1, 24'h600000, d, l, c, k);
    t0 = txn;
    @(negedge clk);
    bus.req_addr[0 +: AW] = 24'h900000;
    bus.req_valid[0] = 1'b1;
    @(negedge clk);
    checks++; if (bus.mem_valid !== 1'b1 || bus.mem_addr !== 24'h900000) begin errors++; $display("FAIL abort_issue got %b %h exp 1 900000", bus.mem_valid, bus.mem_addr); end
    @(negedge clk);
    resetn = 1'b0;
    bus.req_valid[0] = 1'b0;
    @(negedge clk);
    checks++; if (bus.mem_valid !== 1'b0) begin errors++; $display("FAIL abort_mem_valid got %b exp 0", bus.mem_valid); end
    rdy = 0;
    @(negedge clk) resetn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.req_ready !== 2'b00) rdy++;
    end
    checks++; if (rdy !== 0 || txn !== t0) begin errors++; $display("FAIL abort_quiet got ready %0d txn %0d exp 0 %0d", rdy, txn, t0); end
    do_req(0, 24'h800000, d, l, c, k);
    checks++; if (txn !== t0 + 1 || l !== MISS_LAT) begin errors++; $display("FAIL abort_buf0_cleared got txn %0d lat %0d exp %0d %0d", txn, l, t0 + 1, MISS_LAT); end
    do_req(1, 24'h600000, d, l, c, k);
    checks++; if (txn !== t0 + 2 || d !== mdl(24'h600000)) begin errors++; $display("FAIL abort_buf1_cleared got txn %0d data %h exp %0d %h", txn, d, t0 + 2, mdl(24'h600000)); end
  endtask

  task automatic test_drop_mid_miss;
    logic [31:0] d; int l, c, t0, rdy; bit k;
    t0 = txn;
    @(negedge clk);
    bus.req_addr[0 +: AW] = 24'hA00000;
    bus.req_valid[0] = 1'b1;
    @(negedge clk);
    checks++; if (bus.mem_valid !== 1'b1) begin errors++; $display("FAIL drop_issue got %b exp 1", bus.mem_valid); end
    @(negedge clk) bus.req_valid[0] = 1'b0;
    rdy = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.req_ready[0] === 1'b1) rdy++;
    end
    checks++; if (rdy !== 0 || txn !== t0 + 1) begin errors++; $display("FAIL drop_no_ready got ready %0d txn %0d exp 0 %0d", rdy, txn, t0 + 1); end
    do_req(0, 24'hA00002, d, l, c, k);
    checks++; if (l !== 1 || d !== mdl(24'hA00000) || txn !== t0 + 1) begin errors++; $display("FAIL drop_rehit got lat %0d data %h txn %0d exp 1 %h %0d", l, d, txn, mdl(24'hA00000), t0 + 1); end
  endtask

  initial begin
    resetn        = 1'b0;
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.inval     = 1'b0;
    test_reset();
    test_cold_miss();
    test_hit();
    test_contention();
    test_parallel_hit();
    test_inval();
    test_abort_reset();
    test_drop_mid_miss();
    checks++; if (gap_err !== 0) begin errors++; $display("FAIL final_mem_valid_gap got %0d exp 0", gap_err); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
